instr_encoder: RTL

//  LEGv8 instruction encoder: the inverse of the main decoder. Takes mnemonic-level requests
//  (op + register fields + immediate), assembles 32-bit R/D/CB machine words, flags illegal

---
 rtl/instr_encoder_if.sv | 25 ++
 rtl/instr_encoder.sv | 116 +++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request/result handshake bundle for the LEGv8 instruction encoder.
// Master issues mnemonic requests and consumes words; slave is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_sel;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [18:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        out_err;

  modport master (
    output in_valid, op_sel, rd, rn, rm, imm, out_ready,
    input  in_ready, out_valid, instr, out_err
  );

  modport slave (
    input  in_valid, op_sel, rd, rn, rm, imm, out_ready,
    output in_ready, out_valid, instr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// LEGv8 R/D/CB instruction encoder with a 2-entry output FIFO.
// Illegal requests yield instr=0 with out_err set.
module instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  logic is_ld, is_st, is_cb;
  logic is_add, is_sub, is_and, is_orr;
  logic d_ok;
  logic [10:0] r_opc;
  logic [31:0] enc_word;
  logic        enc_err;

  assign is_ld  = bus.op_sel == 3'd0;
  assign is_st  = bus.op_sel == 3'd1;
  assign is_cb  = bus.op_sel == 3'd2;
  assign is_add = bus.op_sel == 3'd3;
  assign is_sub = bus.op_sel == 3'd4;
  assign is_and = bus.op_sel == 3'd5;
  assign is_orr = bus.op_sel == 3'd6;

  // DT_address is 9 bits signed: upper imm bits must be pure sign extension
  assign d_ok = (&bus.imm[18:8]) | ~(|bus.imm[18:8]);

  always_comb begin
    r_opc    = OPC_ADD;
    enc_word = 32'h0;
    enc_err  = 1'b0;
    unique case (1'b1)
      is_ld, is_st: begin
        enc_err = !d_ok;
        if (d_ok)
          enc_word = {is_ld ? OPC_LDUR : OPC_STUR,
                      bus.imm[8:0], 2'b00, bus.rn, bus.rd};
      end
      is_cb: enc_word = {OPC_CBZ, bus.imm, bus.rd};
      is_add, is_sub, is_and, is_orr: begin
        unique case (1'b1)
          is_sub:  r_opc = OPC_SUB;
          is_and:  r_opc = OPC_AND;
          is_orr:  r_opc = OPC_ORR;
          default: r_opc = OPC_ADD;
        endcase
        enc_word = {r_opc, bus.rm, 6'b0, bus.rn, bus.rd};
      end
      default: enc_err = 1'b1;
    endcase
  end

  logic [1:0][32:0] mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign bus.in_ready  = count_q < 2'(DEPTH);
  assign bus.out_valid = count_q != 2'd0;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  assign {bus.out_err, bus.instr} =
    bus.out_valid ? mem_q[rd_ptr_q] : 33'h0;
  assign issued_cnt = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {enc_err, enc_word};
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      cnt_d    = cnt_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
